// File: rtl/stk_adm_arb_if.sv
// Admission arbiter bundle: engine commands, allocator
// status/strobe, completions and LK-stage launch.
interface stk_adm_arb_if #(
  parameter int ENGS_N  = 4,
  parameter int ENGID_W = $clog2(ENGS_N)
);
  logic [ENGS_N-1:0]  i_cmd_vld;
  logic [ENGS_N-1:0]  i_cmd_push;
  logic [ENGS_N-1:0]  o_cmd_ack;
  logic               i_al_empty_r;
  logic               i_al_busy_r;
  logic               o_al_alloc;
  logic [ENGS_N-1:0]  i_rsp_vld;
  logic               o_lk_vld_r;
  logic [ENGID_W-1:0] o_lk_engid_r;
  logic               o_lk_push_r;
  logic [ENGS_N-1:0]  o_inflight_r;

  modport slave (
    input  i_cmd_vld, i_cmd_push,
    input  i_al_empty_r, i_al_busy_r,
    input  i_rsp_vld,
    output o_cmd_ack, o_al_alloc,
    output o_lk_vld_r, o_lk_engid_r,
    output o_lk_push_r, o_inflight_r
  );

  modport master (
    output i_cmd_vld, i_cmd_push,
    output i_al_empty_r, i_al_busy_r,
    output i_rsp_vld,
    input  o_cmd_ack, o_al_alloc,
    input  o_lk_vld_r, o_lk_engid_r,
    input  o_lk_push_r, o_inflight_r
  );
endinterface

// File: rtl/stk_adm_arb.sv
// Round-robin admission arbiter: one issue slot, one
// outstanding command per engine, push gated by allocator.
module stk_adm_arb #(
  parameter int ENGS_N  = 4,
  parameter int ENGID_W = $clog2(ENGS_N)
) (
  input  logic         clk,
  input  logic         arst_n,
  stk_adm_arb_if.slave bus
);

  logic [ENGS_N-1:0]  inflight_q, inflight_d;
  logic [ENGS_N-1:0]  elig, ack;
  logic [ENGID_W-1:0] rr_q, rr_d;
  logic [ENGID_W-1:0] engid_q, engid_d;
  logic [ENGID_W-1:0] win, idx;
  logic               found, gnt, blk;
  logic               rdy_q;
  logic               lk_vld_q, lk_vld_d;
  logic               lk_push_q, lk_push_d;

  assign blk  = bus.i_al_empty_r | bus.i_al_busy_r;
  assign elig = bus.i_cmd_vld & ~inflight_q
              & ~(bus.i_cmd_push & {ENGS_N{blk}});

  // Wrap-around scan starting at the rr pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < ENGS_N; k++) begin
      idx = ENGID_W'((int'(rr_q) + k) % ENGS_N);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign gnt = found & rdy_q;

  always_comb begin
    ack = '0;
    if (gnt) ack[win] = 1'b1;
  end

  assign inflight_d = (inflight_q & ~bus.i_rsp_vld) | ack;
  assign lk_vld_d   = gnt;
  assign rr_d       = gnt
                    ? ENGID_W'((int'(win) + 1) % ENGS_N)
                    : rr_q;
  assign engid_d    = gnt ? win : engid_q;
  assign lk_push_d  = gnt ? bus.i_cmd_push[win] : lk_push_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_q      <= 1'b0;
      inflight_q <= '0;
      rr_q       <= '0;
      lk_vld_q   <= 1'b0;
      engid_q    <= '0;
      lk_push_q  <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      lk_vld_q   <= lk_vld_d;
      engid_q    <= engid_d;
      lk_push_q  <= lk_push_d;
    end
  end

  assign bus.o_cmd_ack    = ack;
  assign bus.o_al_alloc   = gnt & bus.i_cmd_push[win];
  assign bus.o_lk_vld_r   = lk_vld_q;
  assign bus.o_lk_engid_r = engid_q;
  assign bus.o_lk_push_r  = lk_push_q;
  assign bus.o_inflight_r = inflight_q;

endmodule

// File: tb/tb_stk_adm_arb.sv
// Directed bench for stk_adm_arb with ENGS_N=4:
// hand-computed grant, lock and allocator-gating vectors.
module tb_stk_adm_arb;

  logic clk = 1'b0;
  logic arst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stk_adm_arb_if #(.ENGS_N(4)) bus ();

  stk_adm_arb #(.ENGS_N(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    oh = 4'b0001 << i;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_cmd_vld    = '0;
    bus.i_cmd_push   = '0;
    bus.i_rsp_vld    = '0;
    bus.i_al_empty_r = 1'b0;
    bus.i_al_busy_r  = 1'b0;
  endtask

  task automatic clean();
    cyc();
    arst_n = 1'b0;
    idle_in();
    cyc();
    arst_n = 1'b1;
    cyc();
  endtask

  // A response for an engine with no lock must never be sent
  always @(negedge clk)
    if (arst_n === 1'b1)
      chk("rsp_legal",
          32'(bus.i_rsp_vld & ~bus.o_inflight_r), 32'd0);

  initial begin
    arst_n = 1'b0;
    idle_in();
    cyc();
    chk("rst_ack",   32'(bus.o_cmd_ack),    32'd0);
    chk("rst_alloc", 32'(bus.o_al_alloc),   32'd0);
    chk("rst_lkv",   32'(bus.o_lk_vld_r),   32'd0);
    chk("rst_eng",   32'(bus.o_lk_engid_r), 32'd0);
    chk("rst_push",  32'(bus.o_lk_push_r),  32'd0);
    chk("rst_infl",  32'(bus.o_inflight_r), 32'd0);

    arst_n = 1'b1;
    bus.i_cmd_vld = 4'hF;
    #1;
    chk("rel_gated", 32'(bus.o_cmd_ack), 32'd0);

    // Round robin, each response one cycle after LK
    for (int k = 0; k < 12; k++) begin
      cyc();
      bus.i_cmd_vld = 4'hF;
      bus.i_rsp_vld = (k >= 2) ? oh((k - 2) % 4) : 4'h0;
      #1;
      chk("rr_ack", 32'(bus.o_cmd_ack), 32'(oh(k % 4)));
      if (k >= 1) begin
        chk("rr_lkv", 32'(bus.o_lk_vld_r), 32'd1);
        chk("rr_eng", 32'(bus.o_lk_engid_r), 32'((k - 1) % 4));
      end
      if (k >= 2)
        chk("rr_infl", 32'(bus.o_inflight_r),
            32'(oh((k - 1) % 4) | oh((k - 2) % 4)));
    end

    // Reset in the middle of traffic
    cyc();
    arst_n = 1'b0;
    bus.i_rsp_vld = '0;
    #1;
    chk("mid_ack",   32'(bus.o_cmd_ack),    32'd0);
    chk("mid_alloc", 32'(bus.o_al_alloc),   32'd0);
    chk("mid_lkv",   32'(bus.o_lk_vld_r),   32'd0);
    chk("mid_eng",   32'(bus.o_lk_engid_r), 32'd0);
    chk("mid_push",  32'(bus.o_lk_push_r),  32'd0);
    chk("mid_infl",  32'(bus.o_inflight_r), 32'd0);
    cyc();
    arst_n = 1'b1;
    #1;
    chk("mid_gated", 32'(bus.o_cmd_ack), 32'd0);
    cyc();
    chk("mid_first", 32'(bus.o_cmd_ack), 32'h1);

    // In-flight lock on engine 2
    clean();
    cyc();
    bus.i_cmd_vld = 4'b0100;
    #1;
    chk("lock_ack", 32'(bus.o_cmd_ack), 32'h4);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 1) begin
        chk("lock_lkv", 32'(bus.o_lk_vld_r), 32'd1);
        chk("lock_eng", 32'(bus.o_lk_engid_r), 32'd2);
      end
      chk("lock_noack", 32'(bus.o_cmd_ack), 32'd0);
      chk("lock_infl", 32'(bus.o_inflight_r[2]), 32'd1);
    end
    cyc();
    bus.i_rsp_vld = 4'b0100;
    #1;
    chk("lock_rspcyc", 32'(bus.o_cmd_ack), 32'd0);
    cyc();
    bus.i_rsp_vld = '0;
    #1;
    chk("lock_reack", 32'(bus.o_cmd_ack), 32'h4);

    // Allocator empty: push waits, pop passes
    clean();
    cyc();
    bus.i_al_empty_r = 1'b1;
    bus.i_cmd_vld    = 4'b0011;
    bus.i_cmd_push   = 4'b0001;
    #1;
    chk("emp_ack",   32'(bus.o_cmd_ack),  32'h2);
    chk("emp_alloc", 32'(bus.o_al_alloc), 32'd0);
    cyc();
    bus.i_cmd_vld = 4'b0001;
    #1;
    chk("emp_wait",  32'(bus.o_cmd_ack),    32'd0);
    chk("emp_eng",   32'(bus.o_lk_engid_r), 32'd1);
    chk("emp_lkp",   32'(bus.o_lk_push_r),  32'd0);
    cyc();
    bus.i_al_empty_r = 1'b0;
    #1;
    chk("emp_go",    32'(bus.o_cmd_ack),  32'h1);
    chk("emp_alloc1", 32'(bus.o_al_alloc), 32'd1);
    cyc();
    bus.i_cmd_vld = '0;
    #1;
    chk("emp_lkv",   32'(bus.o_lk_vld_r),   32'd1);
    chk("emp_eng0",  32'(bus.o_lk_engid_r), 32'd0);
    chk("emp_lkp1",  32'(bus.o_lk_push_r),  32'd1);

    // Allocator busy with only pushes pending
    clean();
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.i_al_busy_r = 1'b1;
      bus.i_cmd_vld   = 4'b1001;
      bus.i_cmd_push  = 4'b1001;
      #1;
      chk("busy_ack",   32'(bus.o_cmd_ack),  32'd0);
      chk("busy_alloc", 32'(bus.o_al_alloc), 32'd0);
    end
    cyc();
    bus.i_al_busy_r = 1'b0;
    #1;
    chk("busy_go",    32'(bus.o_cmd_ack),  32'h1);
    chk("busy_alloc1", 32'(bus.o_al_alloc), 32'd1);

    // Wrap with response while lock still set
    clean();
    cyc();
    bus.i_cmd_vld = 4'b0010;
    #1;
    chk("wr_ack1", 32'(bus.o_cmd_ack), 32'h2);
    cyc();
    bus.i_cmd_vld = 4'b0110;
    #1;
    chk("wr_ack2", 32'(bus.o_cmd_ack), 32'h4);
    cyc();
    bus.i_cmd_vld = 4'b0010;
    bus.i_rsp_vld = 4'b0010;
    #1;
    chk("wr_nobyp", 32'(bus.o_cmd_ack),    32'd0);
    chk("wr_infl",  32'(bus.o_inflight_r), 32'h6);
    cyc();
    bus.i_rsp_vld = '0;
    #1;
    chk("wr_ack3",  32'(bus.o_cmd_ack),    32'h2);
    chk("wr_infl2", 32'(bus.o_inflight_r), 32'h4);
    cyc();
    bus.i_cmd_vld = 4'b1011;
    #1;
    chk("wr_eng",   32'(bus.o_lk_engid_r), 32'd1);
    chk("wr_rr2",   32'(bus.o_cmd_ack),    32'h8);

    cyc();
    idle_in();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
